// File: rtl/coherent_memory_arbiter.sv
// coherent_memory_arbiter
//   Snooping bus controller that sits between N per-CPU I/D cache pairs and a
//   single-port RAM. Data requests are arbitrated round-robin and always win
//   over instruction fetches. A block read first snoops every other core. If a
//   core holds the block dirty, that core's data is forwarded cache-to-cache to
//   the requester while the same data is written back to RAM. Cache blocks move
//   as WORDS-beat bursts, and the controller generates each beat address.
//
//   RAM handshake encoding (i_ramstate): 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
//   A beat completes only in a cycle where i_ramstate == ACCESS.
//
// Ports
//   i_clk, i_nrst               clock (rising edge), async active-low reset
//   i_iren/i_iaddr              instruction fetch request + word address per CPU
//   o_iwait/o_iload             fetch wait (low one cycle = data valid), fetch data
//   i_dren/i_dwen/i_daddr       block read / block writeback request + block address
//   i_dstore                    writeback (or snoop-forward) word for current beat
//   o_dwait/o_dload             beat accepted / read data valid, data to requester
//   i_ccwrite                   requester: read-exclusive; snoopee: holds dirty copy
//   o_ccwait/o_ccinv            snoop in progress / invalidate line
//   o_ccsnoopaddr               block base address being snooped
//   o_ramren/o_ramwen/o_ramaddr/o_ramstore, i_ramload, i_ramstate   RAM side
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | arbitrate: data requests first, then instruction fetches
// S_WB     | block writeback from the granted D-cache to RAM
// S_SNOOP  | one cycle: snoop all other cores for the requested block
// S_SWB    | dirty snoopee forwards the block to requester and to RAM
// S_LD     | block read from RAM into the granted D-cache
// S_IFETCH | single-word instruction fetch from RAM
module coherent_memory_arbiter #(
    parameter int CPUS  = 2,
    parameter int WORDS = 2
) (
    input  logic                       i_clk,
    input  logic                       i_nrst,
    input  logic [CPUS-1:0]            i_iren,
    input  logic [CPUS-1:0][31:0]      i_iaddr,
    output logic [CPUS-1:0]            o_iwait,
    output logic [CPUS-1:0][31:0]      o_iload,
    input  logic [CPUS-1:0]            i_dren,
    input  logic [CPUS-1:0]            i_dwen,
    input  logic [CPUS-1:0][31:0]      i_daddr,
    input  logic [CPUS-1:0][31:0]      i_dstore,
    output logic [CPUS-1:0]            o_dwait,
    output logic [CPUS-1:0][31:0]      o_dload,
    input  logic [CPUS-1:0]            i_ccwrite,
    output logic [CPUS-1:0]            o_ccwait,
    output logic [CPUS-1:0]            o_ccinv,
    output logic [CPUS-1:0][31:0]      o_ccsnoopaddr,
    output logic                       o_ramren,
    output logic                       o_ramwen,
    output logic [31:0]                o_ramaddr,
    output logic [31:0]                o_ramstore,
    input  logic [31:0]                i_ramload,
    input  logic [1:0]                 i_ramstate
);

    localparam int          PW        = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam int          BW        = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [31:0] BLK_MASK  = 32'(WORDS * 4 - 1);
    localparam logic [1:0]  RS_ACCESS = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB,
        S_SNOOP,
        S_SWB,
        S_LD,
        S_IFETCH
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [PW-1:0]   r_dptr;
    logic [PW-1:0]   r_iptr;
    logic [PW-1:0]   r_dgnt;
    logic [PW-1:0]   r_ignt;
    logic [PW-1:0]   r_src;
    logic [BW-1:0]   r_beat;

    logic [CPUS-1:0] w_dreq;
    logic [CPUS-1:0] w_dirty;
    logic [PW-1:0]   w_dwin;
    logic [PW-1:0]   w_iwin;
    logic [PW-1:0]   w_src;
    logic            w_dany;
    logic            w_iany;
    logic            w_access;
    logic            w_last;
    logic [31:0]     w_base;
    logic [31:0]     w_burst_addr;

    assign w_access     = (i_ramstate == RS_ACCESS);
    assign w_last       = (r_beat == BW'(WORDS - 1));
    assign w_base       = i_daddr[r_dgnt] & ~BLK_MASK;
    assign w_burst_addr = w_base | (32'(r_beat) << 2);

    // Round-robin pick: scanning offsets from the top down and overwriting
    // leaves the requester closest at/after the pointer.
    always_comb begin
        w_dreq  = i_dren | i_dwen;
        w_dwin  = '0;
        w_dany  = 1'b0;
        w_iwin  = '0;
        w_iany  = 1'b0;
        w_dirty = '0;
        w_src   = '0;
        for (int o = CPUS - 1; o >= 0; o--) begin
            if (w_dreq[(int'(r_dptr) + o) % CPUS]) begin
                w_dwin = PW'((int'(r_dptr) + o) % CPUS);
                w_dany = 1'b1;
            end
            if (i_iren[(int'(r_iptr) + o) % CPUS]) begin
                w_iwin = PW'((int'(r_iptr) + o) % CPUS);
                w_iany = 1'b1;
            end
        end
        // The requester's own ccwrite means read-exclusive, not dirty.
        for (int k = CPUS - 1; k >= 0; k--) begin
            if (i_ccwrite[k] && (PW'(k) != r_dgnt)) begin
                w_dirty[k] = 1'b1;
                w_src      = PW'(k);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state <= S_IDLE;
            r_dptr  <= '0;
            r_iptr  <= '0;
            r_dgnt  <= '0;
            r_ignt  <= '0;
            r_src   <= '0;
            r_beat  <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    r_beat <= '0;
                    if (w_dany) begin
                        r_dgnt <= w_dwin;
                        r_dptr <= PW'((int'(w_dwin) + 1) % CPUS);
                    end else if (w_iany) begin
                        r_ignt <= w_iwin;
                        r_iptr <= PW'((int'(w_iwin) + 1) % CPUS);
                    end
                end
                S_SNOOP: r_src <= w_src;
                S_WB, S_SWB, S_LD: begin
                    if (w_access) begin
                        r_beat <= w_last ? '0 : r_beat + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next_state  = r_state;
        o_iwait       = '1;
        o_dwait       = '1;
        o_dload       = '0;
        o_ccwait      = '0;
        o_ccinv       = '0;
        o_ccsnoopaddr = '0;
        o_ramren      = 1'b0;
        o_ramwen      = 1'b0;
        o_ramaddr     = '0;
        o_ramstore    = '0;
        for (int k = 0; k < CPUS; k++) begin
            o_iload[k] = i_ramload;
        end

        case (r_state)
            S_IDLE: begin
                if (w_dany) begin
                    // Writeback wins over a read from the same core.
                    w_next_state = i_dwen[w_dwin] ? S_WB : S_SNOOP;
                end else if (w_iany) begin
                    w_next_state = S_IFETCH;
                end
            end
            S_WB: begin
                o_ramwen   = 1'b1;
                o_ramaddr  = w_burst_addr;
                o_ramstore = i_dstore[r_dgnt];
                if (w_access) begin
                    o_dwait[r_dgnt] = 1'b0;
                    if (w_last) w_next_state = S_IDLE;
                end
            end
            S_SNOOP: begin
                for (int k = 0; k < CPUS; k++) begin
                    if (PW'(k) != r_dgnt) begin
                        o_ccwait[k]      = 1'b1;
                        o_ccsnoopaddr[k] = w_base;
                        o_ccinv[k]       = i_ccwrite[r_dgnt];
                    end
                end
                w_next_state = (|w_dirty) ? S_SWB : S_LD;
            end
            S_SWB: begin
                o_ccwait[r_src]      = 1'b1;
                o_ccsnoopaddr[r_src] = w_base;
                o_ramwen             = 1'b1;
                o_ramaddr            = w_burst_addr;
                o_ramstore           = i_dstore[r_src];
                if (w_access) begin
                    o_dload[r_dgnt] = i_dstore[r_src];
                    o_dwait[r_dgnt] = 1'b0;
                    o_dwait[r_src]  = 1'b0;
                    if (w_last) w_next_state = S_IDLE;
                end
            end
            S_LD: begin
                o_ramren  = 1'b1;
                o_ramaddr = w_burst_addr;
                if (w_access) begin
                    o_dload[r_dgnt] = i_ramload;
                    o_dwait[r_dgnt] = 1'b0;
                    if (w_last) w_next_state = S_IDLE;
                end
            end
            S_IFETCH: begin
                o_ramren  = 1'b1;
                o_ramaddr = i_iaddr[r_ignt];
                if (w_access) begin
                    o_iwait[r_ignt] = 1'b0;
                    w_next_state    = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_coherent_memory_arbiter.sv
// Directed-vector bench for coherent_memory_arbiter (CPUS=2, WORDS=2).
// The RAM model returns ramaddr ^ 0x5A5A0000 so read data is predictable.
module tb_coherent_memory_arbiter;

    localparam logic [1:0] A = 2'd2;
    localparam logic [1:0] B = 2'd1;

    logic             clk;
    logic             rst_n;
    logic [1:0]       iren, dren, dwen, ccwrite;
    logic [1:0][31:0] iaddr, daddr, dstore;
    logic [1:0]       iwait, dwait, ccwait, ccinv;
    logic [1:0][31:0] iload, dload, snoopaddr;
    logic             ramren, ramwen;
    logic [31:0]      ramaddr, ramstore, ramload;
    logic [1:0]       ramstate;

    int n_run  = 0;
    int n_fail = 0;

    assign ramload = ramaddr ^ 32'h5A5A_0000;

    coherent_memory_arbiter #(.CPUS(2), .WORDS(2)) dut (
        .i_clk(clk), .i_nrst(rst_n),
        .i_iren(iren), .i_iaddr(iaddr), .o_iwait(iwait), .o_iload(iload),
        .i_dren(dren), .i_dwen(dwen), .i_daddr(daddr), .i_dstore(dstore),
        .o_dwait(dwait), .o_dload(dload),
        .i_ccwrite(ccwrite), .o_ccwait(ccwait), .o_ccinv(ccinv), .o_ccsnoopaddr(snoopaddr),
        .o_ramren(ramren), .o_ramwen(ramwen), .o_ramaddr(ramaddr), .o_ramstore(ramstore),
        .i_ramload(ramload), .i_ramstate(ramstate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  dren, dwen, iren, ccw, rs;
        logic [31:0] ds0, ds1;
        logic [1:0]  e_dw, e_iw, e_ccw, e_inv;
        logic        e_ren, e_wen;
        logic [31:0] e_addr, e_store, e_dl0, e_dl1, e_snp0, e_snp1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string n, input logic [1:0] dr, dw, ir, cw, rs,
                                input logic [31:0] s0, s1,
                                input logic [1:0] edw, eiw, eccw, einv,
                                input logic eren, ewen,
                                input logic [31:0] ea, es, el0, el1, ep0, ep1);
        vec_t v;
        v.name = n; v.dren = dr; v.dwen = dw; v.iren = ir; v.ccw = cw; v.rs = rs;
        v.ds0 = s0; v.ds1 = s1; v.e_dw = edw; v.e_iw = eiw; v.e_ccw = eccw; v.e_inv = einv;
        v.e_ren = eren; v.e_wen = ewen; v.e_addr = ea; v.e_store = es;
        v.e_dl0 = el0; v.e_dl1 = el1; v.e_snp0 = ep0; v.e_snp1 = ep1;
        return v;
    endfunction

    // Idle-output record: every wait high, nothing on the RAM or snoop side.
    function automatic vec_t idl(input string n, input logic [1:0] dr, dw, ir,
                                 input logic [31:0] s0, s1);
        return mk(n, dr, dw, ir, 2'b00, A, s0, s1, 2'b11, 2'b11, 2'b00, 2'b00,
                  1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic apply(input vec_t v);
        dren = v.dren; dwen = v.dwen; iren = v.iren; ccwrite = v.ccw; ramstate = v.rs;
        dstore[0] = v.ds0; dstore[1] = v.ds1;
    endtask

    task automatic check(input vec_t v);
        n_run++;
        if (dwait !== v.e_dw || iwait !== v.e_iw || ccwait !== v.e_ccw || ccinv !== v.e_inv ||
            ramren !== v.e_ren || ramwen !== v.e_wen || ramaddr !== v.e_addr ||
            ramstore !== v.e_store || dload[0] !== v.e_dl0 || dload[1] !== v.e_dl1 ||
            snoopaddr[0] !== v.e_snp0 || snoopaddr[1] !== v.e_snp1) begin
            n_fail++;
            $display("FAIL %s: got dw=%b iw=%b ccw=%b inv=%b ren=%b wen=%b addr=%h st=%h dl=%h/%h snp=%h/%h ; want dw=%b iw=%b ccw=%b inv=%b ren=%b wen=%b addr=%h st=%h dl=%h/%h snp=%h/%h",
                     v.name, dwait, iwait, ccwait, ccinv, ramren, ramwen, ramaddr, ramstore,
                     dload[0], dload[1], snoopaddr[0], snoopaddr[1],
                     v.e_dw, v.e_iw, v.e_ccw, v.e_inv, v.e_ren, v.e_wen, v.e_addr, v.e_store,
                     v.e_dl0, v.e_dl1, v.e_snp0, v.e_snp1);
        end
    endtask

    task automatic step(input vec_t v);
        @(negedge clk);
        apply(v);
        #1;
        check(v);
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0;
        iaddr[0] = 32'h40;  iaddr[1] = 32'h80;
        daddr[0] = 32'h104; daddr[1] = 32'h200;   // CPU0 offset bit must be ignored
        apply(idl("init", 0, 0, 0, 0, 0));

        // Read miss, no dirty sharer; CPU0 asks exclusive so CPU1 is invalidated.
        vecs.push_back(idl("rst_idle", 0, 0, 0, 0, 0));
        vecs.push_back(idl("t1_req", 2'b01, 0, 0, 0, 0));
        vecs.push_back(mk("t1_snoop", 2'b01, 0, 0, 2'b01, A, 0, 0, 2'b11, 2'b11, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 0, 32'h100));
        vecs.push_back(mk("t1_ld0", 2'b01, 0, 0, 0, A, 0, 0, 2'b10, 2'b11, 0, 0, 1, 0, 32'h100, 0, 32'h5A5A0100, 0, 0, 0));
        vecs.push_back(mk("t1_ld1_drop", 0, 0, 0, 0, A, 0, 0, 2'b10, 2'b11, 0, 0, 1, 0, 32'h104, 0, 32'h5A5A0104, 0, 0, 0));
        vecs.push_back(idl("t1_idle", 0, 0, 0, 0, 0));
        // CPU1 read, CPU0 dirty: forward + writeback.
        vecs.push_back(idl("t2_req", 2'b10, 0, 0, 0, 0));
        vecs.push_back(mk("t2_snoop", 2'b10, 0, 0, 2'b01, A, 0, 0, 2'b11, 2'b11, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 32'h200, 0));
        vecs.push_back(mk("t2_swb0", 2'b10, 0, 0, 2'b01, A, 32'hAAAA, 0, 2'b00, 2'b11, 2'b01, 0, 0, 1, 32'h200, 32'hAAAA, 0, 32'hAAAA, 32'h200, 0));
        vecs.push_back(mk("t2_swb1", 0, 0, 0, 2'b01, A, 32'hBBBB, 0, 2'b00, 2'b11, 2'b01, 0, 0, 1, 32'h204, 32'hBBBB, 0, 32'hBBBB, 32'h200, 0));
        vecs.push_back(idl("t2_idle", 0, 0, 0, 0, 0));
        // Data beats instruction; RAM busy 3 cycles mid-LD; then the fetch.
        vecs.push_back(idl("t4_req", 2'b10, 0, 2'b01, 0, 0));
        vecs.push_back(mk("t4_snoop", 2'b10, 0, 2'b01, 0, A, 0, 0, 2'b11, 2'b11, 2'b01, 0, 0, 0, 0, 0, 0, 0, 32'h200, 0));
        vecs.push_back(mk("t4_ld0", 2'b10, 0, 2'b01, 0, A, 0, 0, 2'b01, 2'b11, 0, 0, 1, 0, 32'h200, 0, 0, 32'h5A5A0200, 0, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk($sformatf("t5_busy%0d", i), 2'b10, 0, 2'b01, 0, B, 0, 0, 2'b11, 2'b11, 0, 0, 1, 0, 32'h204, 0, 0, 0, 0, 0));
        vecs.push_back(mk("t5_ld1", 0, 0, 2'b01, 0, A, 0, 0, 2'b01, 2'b11, 0, 0, 1, 0, 32'h204, 0, 0, 32'h5A5A0204, 0, 0));
        vecs.push_back(idl("t4_iidle", 0, 0, 2'b01, 0, 0));
        vecs.push_back(mk("t4_ifetch", 0, 0, 0, 0, A, 0, 0, 2'b11, 2'b10, 0, 0, 1, 0, 32'h40, 0, 0, 0, 0, 0));
        vecs.push_back(idl("t4_idle", 0, 0, 0, 0, 0));
        // Both CPUs write back continuously: grants 0,1,0,1.
        for (int r = 0; r < 4; r++) begin
            logic [31:0] base;
            logic [1:0]  dwv;
            logic [31:0] st;
            base = (r % 2 == 0) ? 32'h100 : 32'h200;
            dwv  = (r % 2 == 0) ? 2'b10 : 2'b01;
            st   = (r % 2 == 0) ? 32'h1000 : 32'h2000;
            vecs.push_back(idl($sformatf("t3_idle%0d", r), 0, 2'b11, 0, 32'h1000, 32'h2000));
            vecs.push_back(mk($sformatf("t3_wb%0d_0", r), 0, 2'b11, 0, 0, A, 32'h1000, 32'h2000, dwv, 2'b11, 0, 0, 0, 1, base, st, 0, 0, 0, 0));
            vecs.push_back(mk($sformatf("t3_wb%0d_1", r), 0, (r == 3) ? 2'b00 : 2'b11, 0, 0, A, 32'h1000, 32'h2000, dwv, 2'b11, 0, 0, 0, 1, base | 32'h4, st, 0, 0, 0, 0));
        end
        vecs.push_back(idl("t3_idle", 0, 0, 0, 0, 0));
        // dREN and dWEN together on CPU0: writeback first.
        vecs.push_back(idl("rw_req", 2'b01, 2'b01, 0, 32'h3000, 0));
        vecs.push_back(mk("rw_wb0", 2'b01, 2'b01, 0, 0, A, 32'h3000, 0, 2'b10, 2'b11, 0, 0, 0, 1, 32'h100, 32'h3000, 0, 0, 0, 0));
        vecs.push_back(mk("rw_wb1", 0, 0, 0, 0, A, 32'h3000, 0, 2'b10, 2'b11, 0, 0, 0, 1, 32'h104, 32'h3000, 0, 0, 0, 0));
        vecs.push_back(idl("rw_idle", 0, 0, 0, 0, 0));

        // Reset-state check before release.
        @(negedge clk);
        #1;
        check(idl("reset", 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) step(vecs[i]);

        // Reset in the middle of a snoop writeback, then a clean restart.
        step(idl("r_req", 2'b10, 0, 0, 0, 0));
        step(mk("r_snoop", 2'b10, 0, 0, 2'b01, A, 0, 0, 2'b11, 2'b11, 2'b01, 0, 0, 0, 0, 0, 0, 0, 32'h200, 0));
        step(mk("r_swb0", 2'b10, 0, 0, 2'b01, A, 32'h1111, 0, 2'b00, 2'b11, 2'b01, 0, 0, 1, 32'h200, 32'h1111, 0, 32'h1111, 32'h200, 0));
        step(mk("r_swb1", 2'b10, 0, 0, 2'b01, A, 32'h2222, 0, 2'b00, 2'b11, 2'b01, 0, 0, 1, 32'h204, 32'h2222, 0, 32'h2222, 32'h200, 0));
        rst_n = 1'b0;
        #1;
        check(mk("r_mid_reset", 2'b10, 0, 0, 2'b01, A, 32'h2222, 0, 2'b11, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        v = idl("r_post", 0, 0, 0, 0, 0);
        apply(v);
        rst_n = 1'b1;
        #1;
        check(v);
        step(idl("r_req2", 2'b01, 0, 0, 0, 0));
        step(mk("r_snoop2", 2'b01, 0, 0, 0, A, 0, 0, 2'b11, 2'b11, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100));
        step(mk("r_ld0", 0, 0, 0, 0, A, 0, 0, 2'b10, 2'b11, 0, 0, 1, 0, 32'h100, 0, 32'h5A5A0100, 0, 0, 0));
        step(mk("r_ld1", 0, 0, 0, 0, A, 0, 0, 2'b10, 2'b11, 0, 0, 1, 0, 32'h104, 0, 32'h5A5A0104, 0, 0, 0));
        step(idl("r_idle", 0, 0, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
